// File: rtl/bit_permute_pipe.sv
// rtl/bit_permute_pipe.sv - multi-channel bit-permutation engine with skid-buffered stream output
// Four per-transaction permutation modes, one-cycle latency, full throughput, wrapping transfer counter.
module bit_permute_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int GROUP    = 4,
  parameter int COUNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [1:0]                out_mode,
  output logic [COUNT_W-1:0]        xfer_count,
  input  logic                      clr_count
);

  localparam int DW = CHANNELS * WIDTH;
  localparam int NG = WIDTH / GROUP;

  function automatic logic [WIDTH-1:0] permute_lane(input logic [WIDTH-1:0] x,
                                                    input logic [1:0] mode);
    logic [WIDTH-1:0] y;
    y = x;
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        case (mode)
          2'd1:    y[j*GROUP+i] = x[WIDTH-1-(j*GROUP+i)];
          2'd2:    y[j*GROUP+i] = x[(NG-1-j)*GROUP+i];
          2'd3:    y[j*GROUP+i] = x[j*GROUP+GROUP-1-i];
          default: y[j*GROUP+i] = x[j*GROUP+i];
        endcase
      end
    end
    return y;
  endfunction

  logic [DW-1:0] perm_data;
  logic [DW-1:0] skid_data;
  logic [1:0]    skid_mode;
  logic          skid_full;
  logic          main_free;
  logic          in_xfer;
  logic          out_xfer;
  logic          skid_full_nxt;

  always_comb begin
    perm_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      perm_data[k*WIDTH +: WIDTH] = permute_lane(in_data[k*WIDTH +: WIDTH], in_mode);
    end
  end

  assign main_free = !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Skid holds a word only when the main register cannot take it this edge.
  always_comb begin
    skid_full_nxt = skid_full;
    if (main_free) begin
      skid_full_nxt = skid_full && in_xfer;
    end else if (in_xfer) begin
      skid_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 2'd0;
      skid_data <= '0;
      skid_mode <= 2'd0;
      skid_full <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      skid_full <= skid_full_nxt;
      in_ready  <= !skid_full_nxt;
      if (main_free) begin
        if (skid_full) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          out_mode  <= skid_mode;
          if (in_xfer) begin
            skid_data <= perm_data;
            skid_mode <= in_mode;
          end
        end else if (in_xfer) begin
          out_valid <= 1'b1;
          out_data  <= perm_data;
          out_mode  <= in_mode;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_data <= perm_data;
        skid_mode <= in_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (clr_count) begin
      xfer_count <= '0;
    end else if (out_xfer) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule
